genius_playback_ctrl: RTL and testbench

GENIUS_PLAYBACK_CTRL -- requirements
Module: genius_playback_ctrl

---
 rtl/genius_playback_ctrl.sv | 122 ++++++++++++
 tb/tb_genius_playback_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/genius_playback_ctrl.sv
// Playback sequencer for a Simon-style game: fetches, shows and blanks each symbol of a round,
// then waits for the player to finish or go idle.
module genius_playback_ctrl #(
  parameter int unsigned ON_TICKS      = 12_500_000,
  parameter int unsigned OFF_TICKS     = 6_250_000,
  parameter int unsigned TIMEOUT_TICKS = 250_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] level,
  input  logic [1:0] sym_in,
  input  logic       btn_event,
  input  logic       input_done,
  input  logic       abort,
  output logic       sym_req,
  output logic [3:0] sym_idx,
  output logic       show,
  output logic [1:0] sym_out,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  typedef enum logic [2:0] {StIdle, StFetch, StLatch, StOn, StOff, StWait} state_e;

  localparam logic [31:0] OnLast      = 32'(ON_TICKS - 1);
  localparam logic [31:0] OffLast     = 32'(OFF_TICKS - 1);
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_TICKS - 1);

  state_e      state_q;
  logic [3:0]  len_q;
  logic [3:0]  idx_q;
  logic [1:0]  sym_q;
  logic [31:0] cnt_q;
  logic        done_q;
  logic        timeout_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StIdle;
      len_q     <= '0;
      idx_q     <= '0;
      sym_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      if (abort && (state_q != StIdle)) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              len_q   <= level;
              idx_q   <= '0;
              cnt_q   <= '0;
              state_q <= StFetch;
            end
          end
          StFetch: state_q <= StLatch;
          StLatch: begin
            sym_q   <= sym_in;
            cnt_q   <= '0;
            state_q <= StOn;
          end
          StOn: begin
            if (cnt_q == OnLast) begin
              cnt_q   <= '0;
              state_q <= StOff;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          StOff: begin
            if (cnt_q == OffLast) begin
              cnt_q <= '0;
              // idx stops at len_q, so level=15 plays 16 symbols without wrapping
              if (idx_q == len_q) begin
                state_q <= StWait;
              end else begin
                idx_q   <= idx_q + 4'd1;
                state_q <= StFetch;
              end
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          StWait: begin
            // input_done wins over a button press, which in turn defers expiry
            if (input_done) begin
              cnt_q   <= '0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else if (btn_event) begin
              cnt_q <= '0;
            end else if (cnt_q == TimeoutLast) begin
              cnt_q     <= '0;
              timeout_q <= 1'b1;
              state_q   <= StIdle;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign sym_req = (state_q == StFetch);
  assign sym_idx = idx_q;
  assign show    = (state_q == StOn);
  assign sym_out = (state_q == StOn) ? sym_q : 2'b00;
  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_genius_playback_ctrl.sv
// Directed bench for genius_playback_ctrl with ON=4, OFF=2, TIMEOUT=10.
module tb_genius_playback_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] level = '0;
  logic [1:0] sym_in = '0;
  logic       btn_event = 1'b0;
  logic       input_done = 1'b0;
  logic       abort = 1'b0;
  logic       sym_req;
  logic [3:0] sym_idx;
  logic       show;
  logic [1:0] sym_out;
  logic       busy;
  logic       done;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  genius_playback_ctrl #(
    .ON_TICKS     (4),
    .OFF_TICKS    (2),
    .TIMEOUT_TICKS(10)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .level     (level),
    .sym_in    (sym_in),
    .btn_event (btn_event),
    .input_done(input_done),
    .abort     (abort),
    .sym_req   (sym_req),
    .sym_idx   (sym_idx),
    .show      (show),
    .sym_out   (sym_out),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Plays a full round and leaves the DUT in its first WAIT cycle.
  task automatic drive_round(input logic [3:0] lvl, input logic [1:0] syms [16]);
    int reqs;
    reqs  = 0;
    level = lvl;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i <= int'(lvl); i++) begin
      checks++;
      if (sym_req) reqs++;
      if (sym_req !== 1'b1 || sym_idx !== 4'(i) || busy !== 1'b1 || show !== 1'b0) begin
        errors++;
        $display("FAIL fetch[%0d]: req=%b idx=%0d busy=%b show=%b, want req=1 idx=%0d busy=1 show=0",
                 i, sym_req, sym_idx, busy, show, i);
      end
      sym_in = syms[i];
      tick();
      checks++;
      if (sym_req) reqs++;
      if (sym_req !== 1'b0 || show !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL latch[%0d]: req=%b show=%b busy=%b, want 0 0 1", i, sym_req, show, busy);
      end
      tick();
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (sym_req) reqs++;
        if (show !== 1'b1 || sym_out !== syms[i] || sym_req !== 1'b0) begin
          errors++;
          $display("FAIL on[%0d.%0d]: show=%b sym_out=%0d req=%b, want show=1 sym_out=%0d req=0",
                   i, j, show, sym_out, sym_req, syms[i]);
        end
        tick();
      end
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (sym_req) reqs++;
        if (show !== 1'b0 || sym_out !== 2'd0 || sym_req !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL off[%0d.%0d]: show=%b sym_out=%0d req=%b busy=%b, want 0 0 0 1",
                   i, j, show, sym_out, sym_req, busy);
        end
        tick();
      end
    end
    sym_in = 2'd0;
    checks++;
    if (busy !== 1'b1 || show !== 1'b0 || sym_req !== 1'b0 || done !== 1'b0 ||
        sym_idx !== lvl) begin
      errors++;
      $display("FAIL wait_entry: busy=%b show=%b req=%b done=%b idx=%0d, want 1 0 0 0 idx=%0d",
               busy, show, sym_req, done, sym_idx, lvl);
    end
    checks++;
    if (reqs !== int'(lvl) + 1) begin
      errors++;
      $display("FAIL req_count: got %0d sym_req pulses, want %0d", reqs, int'(lvl) + 1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    tick();
    tick();
    checks++;
    if (sym_req !== 1'b0 || sym_idx !== 4'd0 || show !== 1'b0 || sym_out !== 2'd0 ||
        busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: req=%b idx=%0d show=%b out=%0d busy=%b done=%b to=%b, want all 0",
               sym_req, sym_idx, show, sym_out, busy, done, timeout);
    end
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_symbol();
    logic [1:0] s [16];
    s    = '{default: 2'd0};
    s[0] = 2'd2;
    drive_round(4'd0, s);
    input_done = 1'b1;
    tick();
    input_done = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL single_done: done=%b busy=%b to=%b, want 1 0 0", done, busy, timeout);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done_pulse: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_timeout();
    logic [1:0] s [16];
    s    = '{default: 2'd0};
    s[0] = 2'd1;
    s[1] = 2'd3;
    s[2] = 2'd0;
    drive_round(4'd2, s);
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL timeout_early[%0d]: busy=%b to=%b, want 1 0", k, busy, timeout);
      end
    end
    tick();
    checks++;
    if (timeout !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire: to=%b busy=%b done=%b, want 1 0 0", timeout, busy, done);
    end
    tick();
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: to=%b, want 0", timeout);
    end
  endtask

  task automatic test_btn_extend();
    logic [1:0] s [16];
    s    = '{default: 2'd0};
    s[0] = 2'd3;
    drive_round(4'd0, s);
    for (int k = 0; k < 7; k++) tick();
    btn_event = 1'b1;
    tick();
    btn_event = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL btn_hold[%0d]: busy=%b to=%b, want 1 0", k, busy, timeout);
      end
    end
    // press lands on the would-be expiry cycle
    btn_event = 1'b1;
    tick();
    btn_event = 1'b0;
    checks++;
    if (busy !== 1'b1 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL btn_beats_expiry: busy=%b to=%b, want 1 0", busy, timeout);
    end
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL btn_hold2[%0d]: busy=%b to=%b, want 1 0", k, busy, timeout);
      end
    end
    tick();
    checks++;
    if (timeout !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL btn_timeout: to=%b busy=%b done=%b, want 1 0 0", timeout, busy, done);
    end
    tick();
  endtask

  task automatic test_abort_reset();
    level  = 4'd1;
    sym_in = 2'd2;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    checks++;
    if (show !== 1'b1 || sym_idx !== 4'd1 || sym_out !== 2'd2) begin
      errors++;
      $display("FAIL mid_round_on: show=%b idx=%0d out=%0d, want 1 1 2", show, sym_idx, sym_out);
    end
    level      = 4'd9;
    start      = 1'b1;
    input_done = 1'b1;
    btn_event  = 1'b1;
    tick();
    start      = 1'b0;
    input_done = 1'b0;
    btn_event  = 1'b0;
    checks++;
    if (show !== 1'b1 || sym_out !== 2'd2 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_in_on: show=%b out=%0d busy=%b done=%b, want 1 2 1 0",
               show, sym_out, busy, done);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (show !== 1'b0 || busy !== 1'b0 || sym_idx !== 4'd0 || done !== 1'b0 ||
        timeout !== 1'b0 || sym_out !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid: show=%b busy=%b idx=%0d done=%b to=%b out=%0d, want all 0",
               show, busy, sym_idx, done, timeout, sym_out);
    end
    level = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (busy !== 1'b1 || show !== 1'b0) begin
      errors++;
      $display("FAIL reach_off: busy=%b show=%b, want 1 0", busy, show);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || show !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL abort_off: busy=%b show=%b done=%b to=%b, want 0 0 0 0",
               busy, show, done, timeout);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL abort_settle: busy=%b done=%b to=%b, want 0 0 0", busy, done, timeout);
    end
  endtask

  task automatic test_level15();
    logic [1:0] s [16];
    for (int i = 0; i < 16; i++) s[i] = 2'(i * 3 + 1);
    drive_round(4'd15, s);
    for (int k = 0; k < 9; k++) tick();
    input_done = 1'b1;
    tick();
    input_done = 1'b0;
    checks++;
    if (done !== 1'b1 || timeout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_beats_expiry: done=%b to=%b busy=%b, want 1 0 0", done, timeout, busy);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_symbol();
    test_timeout();
    test_btn_extend();
    test_abort_reset();
    test_level15();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
